// File: rtl/ifetch_if.sv
// Fetch-unit bundle: instruction-memory request/response channel, redirect
// input and decode-side instruction handshake.
// master = fetch unit (drives imem_req/addr and the if_* outputs),
// slave = surrounding core and memory. if_misalign exists only when
// CORE_FETCH_MISALIGN_EN is defined.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
`ifdef CORE_FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output if_valid, if_instr, if_pc,
`ifdef CORE_FETCH_MISALIGN_EN
    output if_misalign,
`endif
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  if_valid, if_instr, if_pc,
`ifdef CORE_FETCH_MISALIGN_EN
    input  if_misalign,
`endif
    output if_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: issues sequential word fetches, buffers up to two
// {pc, instr} pairs in order and hands them to decode; redirects flush the
// buffer and drop the stale responses still in flight.
// Ports: clk, rst (async, active-high), bus (ifetch_if.master: imem_* memory
// channel, redirect/redirect_pc, if_* decode handshake).
// Optional feature macro: CORE_FETCH_MISALIGN_EN (misaligned redirect halts
// fetch and raises if_misalign until the next redirect).
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;        // PC of the next response that will be kept
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        head, tail;
  logic [1:0]  count;          // buffer occupancy
  logic [1:0]  outstanding;    // granted requests without a response yet
  logic [1:0]  discard;        // stale responses still to be dropped
  logic        halted;
  logic        req, grant, rsp, push, pop;
  logic [31:0] redirect_pc_al;

  assign redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};

`ifdef CORE_FETCH_MISALIGN_EN
  logic misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (bus.redirect) begin
      misalign <= |bus.redirect_pc[1:0];
    end
  end

  assign halted          = misalign;
  assign bus.if_misalign = misalign;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Requests are only issued while the in-flight plus buffered total is
  // below two, so a response can never find the buffer full. With a
  // 1-cycle memory this caps throughput at two instructions per three
  // cycles.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  req = !bus.redirect && !halted &&
                  (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
    endcase
  end

  assign grant = req && bus.imem_gnt;
  assign rsp   = bus.imem_rvalid;
  // A response arriving in the redirect cycle belongs to the old stream.
  assign push  = rsp && (discard == 2'd0) && !bus.redirect;
  assign pop   = bus.if_valid && bus.if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= 32'h0;
      end
    end else if (bus.redirect) begin
      // No grant is possible this cycle (req is low), so everything still
      // outstanding after this cycle's response is stale.
      fetch_pc    <= redirect_pc_al;
      resp_pc     <= redirect_pc_al;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      outstanding <= outstanding - 2'(rsp);
      discard     <= outstanding - 2'(rsp);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + 2'(grant) - 2'(rsp);
      if (rsp && (discard != 2'd0)) begin
        discard <= discard - 2'd1;
      end
      if (push) begin
        buf_pc[tail]    <= resp_pc;
        buf_instr[tail] <= bus.imem_rdata;
        tail            <= ~tail;
        resp_pc         <= resp_pc + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = (count != 2'd0) && !halted;
  assign bus.if_instr  = buf_instr[head];
  assign bus.if_pc     = buf_pc[head];

endmodule
